// File: rtl/sprite_pkg.sv
// Shared widths, the transparent colour key and the per-slot attribute record
// for the sprite compositor.
package sprite_pkg;
   localparam int COORD_W = 10;
   localparam int SZ_W    = 7;
   localparam int ADDR_W  = 17;
   localparam int COLOR_W = 12;
   localparam int MAX_SPR = 16;

   localparam logic [COLOR_W-1:0] TRANSPARENT = 12'h000;

   typedef struct packed {
      logic               en;
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
      logic [SZ_W-1:0]    w;
      logic [SZ_W-1:0]    h;
      logic               scale;
      logic [ADDR_W-1:0]  base;
   } sprite_attr_t;

   localparam int ATTR_W = $bits(sprite_attr_t);

   // The attribute bus carries one packed record per slot, slot 0 in the low bits.
   function automatic sprite_attr_t unpack_slot(input logic [MAX_SPR*ATTR_W-1:0] bus,
                                                input int i);
      return bus[i*ATTR_W +: ATTR_W];
   endfunction
endpackage

// File: rtl/sprite_slot.sv
// One sprite slot: frame-shadowed attributes, hit test, registered ROM address
// and the hit flag delayed to line up with the ROM data.
module sprite_slot
   import sprite_pkg::*;
(
   input  logic               clk_25m,
   input  logic               rst,
   input  logic               frame_start,
   input  sprite_attr_t       attr_in,
   input  logic [COORD_W-1:0] hc,
   input  logic [COORD_W-1:0] vc,
   output logic [ADDR_W-1:0]  rom_addr,
   output logic               hit_p2
);
   localparam int CMP_W = COORD_W + 2;

   sprite_attr_t       shadow_q, shadow_d;
   logic               hit_p1_q, hit_p1_d;
   logic               hit_p2_q, hit_p2_d;
   logic [ADDR_W-1:0]  addr_p1_q, addr_p1_d;
   logic [CMP_W-1:0]   hc_w, vc_w, x_lo, x_hi, y_lo, y_hi;
   logic [COORD_W-1:0] dx, dy;

   always_comb begin
      shadow_d = frame_start ? attr_in : shadow_q;
      hc_w     = CMP_W'(hc);
      vc_w     = CMP_W'(vc);
      x_lo     = CMP_W'(shadow_q.x);
      y_lo     = CMP_W'(shadow_q.y);
      // Two extra bits keep a sprite hanging past coordinate 1023 from wrapping to 0
      x_hi     = x_lo + (CMP_W'(shadow_q.w) << shadow_q.scale);
      y_hi     = y_lo + (CMP_W'(shadow_q.h) << shadow_q.scale);
      hit_p1_d = shadow_q.en && (hc_w >= x_lo) && (hc_w < x_hi) &&
                 (vc_w >= y_lo) && (vc_w < y_hi);
      dx       = (hc - shadow_q.x) >> shadow_q.scale;
      dy       = (vc - shadow_q.y) >> shadow_q.scale;
      addr_p1_d = '0;
      if (hit_p1_d)
         addr_p1_d = shadow_q.base + ADDR_W'(dx) + ADDR_W'(shadow_q.w) * ADDR_W'(dy);
      hit_p2_d = hit_p1_q;
   end

   // S1: hit and address registered; S2: hit waits for the ROM read
   always_ff @(posedge clk_25m) begin
      if (rst) begin
         shadow_q  <= '0;
         hit_p1_q  <= 1'b0;
         hit_p2_q  <= 1'b0;
         addr_p1_q <= '0;
      end else begin
         shadow_q  <= shadow_d;
         hit_p1_q  <= hit_p1_d;
         hit_p2_q  <= hit_p2_d;
         addr_p1_q <= addr_p1_d;
      end
   end

   assign rom_addr = addr_p1_q;
   assign hit_p2   = hit_p2_q;
endmodule

// File: rtl/sprite_compositor.sv
// N-slot pipelined sprite compositor: per-slot hit/address units, index-priority
// colour mux over the ROM data and per-frame pixel-accurate collision flags.
module sprite_compositor #(
   parameter int N_SPR   = 8,
   parameter int COORD_W = sprite_pkg::COORD_W,
   parameter int SZ_W    = sprite_pkg::SZ_W,
   parameter int ADDR_W  = sprite_pkg::ADDR_W,
   parameter int COLOR_W = sprite_pkg::COLOR_W
) (
   input  logic                       clk_25m,
   input  logic                       rst,
   input  logic                       valid,
   input  logic [COORD_W-1:0]         hc,
   input  logic [COORD_W-1:0]         vc,
   input  logic                       frame_start,
   input  logic [N_SPR-1:0]           spr_en,
   input  logic [N_SPR*COORD_W-1:0]   spr_x,
   input  logic [N_SPR*COORD_W-1:0]   spr_y,
   input  logic [N_SPR*SZ_W-1:0]      spr_w,
   input  logic [N_SPR*SZ_W-1:0]      spr_h,
   input  logic [N_SPR-1:0]           spr_scale,
   input  logic [N_SPR*ADDR_W-1:0]    spr_base,
   input  logic [COLOR_W-1:0]         bg_color,
   output logic [N_SPR*ADDR_W-1:0]    rom_addr,
   input  logic [N_SPR*COLOR_W-1:0]   rom_data,
   output logic [3:0]                 vgaRed,
   output logic [3:0]                 vgaGreen,
   output logic [3:0]                 vgaBlue,
   output logic [N_SPR-1:0]           collide,
   output logic                       collide_valid
);
   import sprite_pkg::*;

   logic [MAX_SPR*ATTR_W-1:0] attr_bus;
   logic [N_SPR-1:0]          hit_p2, opaque, contrib;
   logic                      vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
   logic [N_SPR-1:0]          acc_q, acc_d, collide_q, collide_d;
   logic                      collide_valid_q, collide_valid_d;
   logic [COLOR_W-1:0]        color_q, color_d;

   for (genvar i = 0; i < N_SPR; i++) begin : g_slot
      sprite_attr_t attr;
      assign attr_bus[i*ATTR_W +: ATTR_W] = {spr_en[i], spr_x[i*COORD_W +: COORD_W],
                                             spr_y[i*COORD_W +: COORD_W], spr_w[i*SZ_W +: SZ_W],
                                             spr_h[i*SZ_W +: SZ_W], spr_scale[i],
                                             spr_base[i*ADDR_W +: ADDR_W]};
      assign attr = unpack_slot(attr_bus, i);
      sprite_slot u_slot (
         .clk_25m     (clk_25m),
         .rst         (rst),
         .frame_start (frame_start),
         .attr_in     (attr),
         .hc          (hc),
         .vc          (vc),
         .rom_addr    (rom_addr[i*ADDR_W +: ADDR_W]),
         .hit_p2      (hit_p2[i])
      );
   end

   if (N_SPR < MAX_SPR) begin : g_pad
      assign attr_bus[MAX_SPR*ATTR_W-1:N_SPR*ATTR_W] = '0;
   end

   always_comb begin
      vld_p1_d = valid;
      vld_p2_d = vld_p1_q;
      opaque   = '0;
      for (int i = 0; i < N_SPR; i++)
         opaque[i] = hit_p2[i] && (rom_data[i*COLOR_W +: COLOR_W] != TRANSPARENT);
      // Walk from the lowest priority up so slot 0 overrides everything
      color_d = bg_color;
      for (int i = N_SPR - 1; i >= 0; i--)
         if (opaque[i]) color_d = rom_data[i*COLOR_W +: COLOR_W];
      if (!vld_p2_q) color_d = '0;
      contrib = '0;
      for (int i = 0; i < N_SPR; i++)
         contrib[i] = vld_p2_q && opaque[i] && ((opaque & ~(N_SPR'(1) << i)) != '0);
      acc_d           = acc_q | contrib;
      collide_d       = collide_q;
      collide_valid_d = 1'b0;
      if (frame_start) begin
         collide_d       = acc_q;
         collide_valid_d = 1'b1;
         acc_d           = '0;
      end
   end

   // S1/S2: valid follows hit and ROM data; S3: colour and collision registered
   always_ff @(posedge clk_25m) begin
      if (rst) begin
         vld_p1_q        <= 1'b0;
         vld_p2_q        <= 1'b0;
         acc_q           <= '0;
         collide_q       <= '0;
         collide_valid_q <= 1'b0;
         color_q         <= '0;
      end else begin
         vld_p1_q        <= vld_p1_d;
         vld_p2_q        <= vld_p2_d;
         acc_q           <= acc_d;
         collide_q       <= collide_d;
         collide_valid_q <= collide_valid_d;
         color_q         <= color_d;
      end
   end

   assign vgaRed        = color_q[COLOR_W-1 -: 4];
   assign vgaGreen      = color_q[COLOR_W-5 -: 4];
   assign vgaBlue       = color_q[3:0];
   assign collide       = collide_q;
   assign collide_valid = collide_valid_q;
endmodule

// File: doc/sprite_compositor.md
# sprite_compositor

Parametrised, pipelined sprite compositor for the 640x480 VGA path on `clk_25m`. It generalises the per-object pixel selection in the display block to N_SPR sprite slots. Each slot has per-frame shadowed attributes, 1x/2x scale, index-based priority and per-frame pixel-accurate collision flags. It sits between the game-logic blocks, which supply positions and enables, and the VGA colour outputs; sprite ROMs are instantiated outside the block.

## Interface
Parameters:
- N_SPR, 8, number of sprite slots; slot 0 has the highest priority.
- COORD_W, 10, width of hc, vc and sprite x, y.
- SZ_W, 7, width of sprite width and height, in source pixels.
- ADDR_W, 17, ROM address width.
- COLOR_W, 12, packed {R4,G4,B4} colour width.

Ports:
- clk_25m  in  1  pixel clock.
- rst  in  1  synchronous, active-high reset.
- valid  in  1  active-video qualifier for hc and vc.
- hc, vc  in  COORD_W each  current pixel coordinate.
- frame_start  in  1  one-cycle pulse, once per frame, in vertical blanking.
- spr_en  in  N_SPR  per-slot enable.
- spr_x, spr_y  in  N_SPR*COORD_W each  top-left corner of each slot.
- spr_w, spr_h  in  N_SPR*SZ_W each  source size; 0 means the slot never hits.
- spr_scale  in  N_SPR  0 = 1x, 1 = 2x.
- spr_base  in  N_SPR*ADDR_W  ROM base address of each slot.
- bg_color  in  COLOR_W  colour used where no sprite is opaque.
- rom_addr  out  N_SPR*ADDR_W  registered address, one per slot ROM.
- rom_data  in  N_SPR*COLOR_W  ROM data; 1-cycle read latency.
- vgaRed, vgaGreen, vgaBlue  out  4 each  registered colour.
- collide  out  N_SPR  collision flags for the previous frame.
- collide_valid  out  1  one-cycle pulse when `collide` updates.

## Operation
- **Shadow attributes.** On `frame_start`, the block copies spr_en, spr_x, spr_y, spr_w, spr_h, spr_scale and spr_base into shadow registers. All rendering uses the shadow values, so attributes never change mid-frame.
- **Hit test (slot i).** With s = spr_scale[i], slot i hits when spr_en[i] is set and x ≤ hc < x + (w<<s) and y ≤ vc < y + (h<<s).
  - All comparisons use COORD_W+2 bits, so a sprite extending past 1023 does not wrap.
- **Address (slot i).** rom_addr = base + ((hc−x)>>s) + w·((vc−y)>>s), truncated to ADDR_W. When slot i does not hit, rom_addr = 0.
- **Opacity.** A pixel is opaque when its hit is set (pipelined to the ROM-data stage) and rom_data ≠ 0. The value 12'h000 is the transparent key.
- **Priority.** The output colour comes from the lowest-index opaque slot. If no slot is opaque, the output is bg_color. If the pipelined valid is low, the output is 0.
- **Collision.**
  - A per-slot sticky accumulator sets bit i on any valid pixel where slot i is opaque and at least one other slot is opaque.
  - On `frame_start`:
    - `collide` takes the accumulator value.
    - `collide_valid` pulses for that cycle.
    - The accumulator clears, and any contribution arriving in the same cycle is dropped.
- **Reset.** All outputs, shadow registers, the accumulator and the pipeline registers go to 0. Shadow spr_en = 0, so nothing is drawn until the first `frame_start`.

## Timing
- 3-stage pipeline:
  - **S1 (edge t+1):** hit flags and rom_addr registered; valid delayed.
  - **S2 (during t+1 → t+2):** ROM presents rom_data by edge t+2; hits and valid are delayed alongside it.
  - **S3 (edge t+3):** priority mux and collision logic drive vgaRed, vgaGreen and vgaBlue.
- The pixel for (hc, vc) sampled at edge t appears on the colour outputs after edge t+3. The VGA timing generator must delay hsync and vsync by 3 cycles.
- Shadow registers update at the `frame_start` edge. Pixels already in S1–S3 finish with the old attributes; because `frame_start` falls in blanking, this has no visible effect.
- `collide` holds its value between pulses. `rst` overrides `frame_start` when both are asserted in the same cycle.

## Structure
- Package `sprite_pkg` holds:
  - COLOR_W, TRANSPARENT = 12'h000, SZ_W and COORD_W defaults;
  - a packed sprite-attribute typedef {en, x, y, w, h, scale, base};
  - the helper function `unpack_slot(bus, i)`.
- Sub-module `sprite_slot`, instantiated N_SPR times, holds one slot's shadow registers, hit test, S1 address register and hit delay.
- The top level holds the valid pipeline, priority mux, collision accumulator and output registers.

## Test plan
- Reset, then `frame_start` with all slots disabled and bg_color = 12'h112 → outputs 12'h112 on valid pixels, 0 on blanking, rom_addr all 0.
- Slot 0 at x=100, y=50, w=30, h=50, base=0, 1x:
  - hc=100, vc=50 → rom_addr[0] = 0;
  - hc=129, vc=99 → rom_addr[0] = 1499;
  - hc=130 → no hit, address 0;
  - colour appears 3 cycles after the hc/vc input.
- Slot 2 at 2x with w=100, base=1000, at x=200, y=200: hc=203, vc=205 → rom_addr = 1000 + 1 + 100·2 = 1201.
- Slots 1 and 3 overlap with both opaque → slot 1 colour is output. If slot 1's ROM returns 0 there → slot 3 colour is output. At the next `frame_start` → collide = 8'b0000_1010 with a one-cycle collide_valid pulse.
- Change spr_x mid-frame (not at `frame_start`) → rendered position unchanged until after the next `frame_start`.
- Assert rst mid-frame with sprites visible → next edge: colours 0, collide 0, shadow enables 0; no sprite drawn until the following `frame_start`.
